// File: rtl/fila_pkg.sv
// Shared definitions for the fila circular-buffer FIFO: occupancy-width helper
// and a bundled status struct for consumers that carry the flags together.
package fila_pkg;

    // Occupancy counter width: must hold every value 0..DEPTH inclusive.
    function automatic int fila_lw(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fila_status_t;

endpackage

// File: rtl/fila_ptr.sv
// Wrapping index counter 0..DEPTH-1 for the FIFO read/write pointers.
// Wraps by explicit compare so any DEPTH works, not only powers of two.
module fila_ptr #(
    parameter  int DEPTH = 8,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_10KHz,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fila_param.sv
// Parametrised circular-buffer FIFO with registered dequeue output, occupancy
// flags, sticky overflow/underflow errors and a synchronous flush.
module fila_param
    import fila_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 8,
    parameter  int AF_THRESH = DEPTH - 1,
    localparam int LW        = fila_lw(DEPTH),
    localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_10KHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enqueue_in,
    input  logic             dequeue_in,
    input  logic             clear_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid_out,
    output logic [LW-1:0]    len_out,
    output logic             full_out,
    output logic             empty_out,
    output logic             almost_full_out,
    output logic             overflow_out,
    output logic             underflow_out
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic [LW-1:0]    count_q,    count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             dvld_q,     dvld_d;
    logic             ovf_q,      ovf_d;
    logic             udf_q,      udf_d;

    logic         deq_ok;
    logic         enq_ok;
    fila_status_t status;

    // A dequeue in the same cycle frees a slot, so a full queue still accepts.
    assign deq_ok = dequeue_in && (count_q != '0);
    assign enq_ok = enqueue_in && ((count_q != LW'(DEPTH)) || deq_ok);

    fila_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .clear     (clear_in),
        .inc       (enq_ok && !clear_in),
        .ptr       (wr_ptr)
    );

    fila_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .clear     (clear_in),
        .inc       (deq_ok && !clear_in),
        .ptr       (rd_ptr)
    );

    always_comb begin
        count_d    = count_q;
        data_out_d = data_out_q;
        dvld_d     = 1'b0;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        if (clear_in) begin
            count_d    = '0;
            data_out_d = '0;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
        end else begin
            if (enq_ok && !deq_ok) begin
                count_d = count_q + LW'(1);
            end else if (deq_ok && !enq_ok) begin
                count_d = count_q - LW'(1);
            end
            if (enqueue_in && !enq_ok) begin
                ovf_d = 1'b1;
            end
            if (dequeue_in && !deq_ok) begin
                udf_d = 1'b1;
            end
            if (deq_ok) begin
                data_out_d = mem_q[rd_ptr];
                dvld_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (enq_ok && !clear_in) begin
            mem_q[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            data_out_q <= '0;
            dvld_q     <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            data_out_q <= data_out_d;
            dvld_q     <= dvld_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign status = '{
        full:        (count_q == LW'(DEPTH)),
        empty:       (count_q == '0),
        almost_full: (count_q >= LW'(AF_THRESH)),
        overflow:    ovf_q,
        underflow:   udf_q
    };

    assign data_out        = data_out_q;
    assign data_valid_out  = dvld_q;
    assign len_out         = count_q;
    assign full_out        = status.full;
    assign empty_out       = status.empty;
    assign almost_full_out = status.almost_full;
    assign overflow_out    = status.overflow;
    assign underflow_out   = status.underflow;

endmodule

// File: tb/tb_fila_param.sv
// Directed bench for fila_param: DEPTH=8 instance (order, overflow, simultaneous,
// clear, async reset) and DEPTH=5/AF=4 instance (pointer wrap, almost-full).
module tb_fila_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    // Instance A: DEPTH=8, AF_THRESH=7
    logic [7:0] a_din  = '0;
    logic       a_enq  = 1'b0;
    logic       a_deq  = 1'b0;
    logic       a_clr  = 1'b0;
    logic [7:0] a_dout;
    logic       a_dv, a_full, a_empty, a_af, a_ovf, a_udf;
    logic [3:0] a_len;

    // Instance B: DEPTH=5, AF_THRESH=4
    logic [7:0] b_din  = '0;
    logic       b_enq  = 1'b0;
    logic       b_deq  = 1'b0;
    logic       b_clr  = 1'b0;
    logic [7:0] b_dout;
    logic       b_dv, b_full, b_empty, b_af, b_ovf, b_udf;
    logic [2:0] b_len;

    fila_param #(.WIDTH(8), .DEPTH(8)) dut_a (
        .clk_10KHz(clk), .reset(rst), .data_in(a_din), .enqueue_in(a_enq),
        .dequeue_in(a_deq), .clear_in(a_clr), .data_out(a_dout),
        .data_valid_out(a_dv), .len_out(a_len), .full_out(a_full),
        .empty_out(a_empty), .almost_full_out(a_af), .overflow_out(a_ovf),
        .underflow_out(a_udf)
    );

    fila_param #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4)) dut_b (
        .clk_10KHz(clk), .reset(rst), .data_in(b_din), .enqueue_in(b_enq),
        .dequeue_in(b_deq), .clear_in(b_clr), .data_out(b_dout),
        .data_valid_out(b_dv), .len_out(b_len), .full_out(b_full),
        .empty_out(b_empty), .almost_full_out(b_af), .overflow_out(b_ovf),
        .underflow_out(b_udf)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] ea, eb;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitors: every data_valid_out pulse must match the next expected word.
    always @(negedge clk) begin
        if (a_dv === 1'b1) begin
            if (qa.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL a_unexpected_valid: got data 0x%0h, expected no pulse (t=%0t)", a_dout, $time);
            end else begin
                ea = qa.pop_front();
                chk("a_dout", int'(a_dout), int'(ea));
            end
        end
        if (b_dv === 1'b1) begin
            if (qb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL b_unexpected_valid: got data 0x%0h, expected no pulse (t=%0t)", b_dout, $time);
            end else begin
                eb = qb.pop_front();
                chk("b_dout", int'(b_dout), int'(eb));
            end
        end
    end

    task automatic stepa(input bit e, input bit d, input bit c, input logic [7:0] din);
        a_enq = e; a_deq = d; a_clr = c; a_din = din;
        @(posedge clk);
        #1;
        a_enq = 1'b0; a_deq = 1'b0; a_clr = 1'b0;
    endtask

    task automatic stepb(input bit e, input bit d, input logic [7:0] din);
        b_enq = e; b_deq = d; b_din = din;
        @(posedge clk);
        #1;
        b_enq = 1'b0; b_deq = 1'b0;
    endtask

    typedef struct {
        bit         e;
        bit         d;
        logic [7:0] din;
        logic [7:0] dout;
        int         len;
        bit         af;
    } vec_t;

    vec_t wrap_tab[16] = '{
        '{1'b1, 1'b0, 8'hC1, 8'h00, 1, 1'b0},
        '{1'b1, 1'b0, 8'hC2, 8'h00, 2, 1'b0},
        '{1'b1, 1'b0, 8'hC3, 8'h00, 3, 1'b0},
        '{1'b1, 1'b0, 8'hC4, 8'h00, 4, 1'b1},
        '{1'b1, 1'b1, 8'hC5, 8'hC1, 4, 1'b1},
        '{1'b1, 1'b1, 8'hC6, 8'hC2, 4, 1'b1},
        '{1'b0, 1'b1, 8'h00, 8'hC3, 3, 1'b0},
        '{1'b1, 1'b1, 8'hC7, 8'hC4, 3, 1'b0},
        '{1'b1, 1'b0, 8'hC8, 8'h00, 4, 1'b1},
        '{1'b1, 1'b1, 8'hC9, 8'hC5, 4, 1'b1},
        '{1'b1, 1'b1, 8'hCA, 8'hC6, 4, 1'b1},
        '{1'b1, 1'b1, 8'hCB, 8'hC7, 4, 1'b1},
        '{1'b0, 1'b1, 8'h00, 8'hC8, 3, 1'b0},
        '{1'b0, 1'b1, 8'h00, 8'hC9, 2, 1'b0},
        '{1'b0, 1'b1, 8'h00, 8'hCA, 1, 1'b0},
        '{1'b0, 1'b1, 8'h00, 8'hCB, 0, 1'b0}
    };

    logic [7:0] ord[3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_len",   int'(a_len),   0);
        chk("rst_empty", int'(a_empty), 1);
        chk("rst_full",  int'(a_full),  0);
        chk("rst_af",    int'(a_af),    0);
        chk("rst_dv",    int'(a_dv),    0);
        chk("rst_dout",  int'(a_dout),  0);
        chk("rst_ovf",   int'(a_ovf),   0);
        chk("rst_udf",   int'(a_udf),   0);
        chk("rst_b_empty", int'(b_empty), 1);
        @(negedge clk);
        rst = 1'b0;

        // Ordering
        for (int i = 0; i < 3; i++) begin
            stepa(1, 0, 0, ord[i]);
            chk("order_len_up", int'(a_len), i + 1);
        end
        for (int i = 0; i < 3; i++) begin
            qa.push_back(ord[i]);
            stepa(0, 1, 0, 8'h00);
            chk("order_len_down", int'(a_len), 2 - i);
        end
        chk("order_empty", int'(a_empty), 1);

        // Fill to full
        for (int i = 1; i <= 8; i++) begin
            stepa(1, 0, 0, 8'(i));
            chk("fill_len",  int'(a_len),  i);
            chk("fill_full", int'(a_full), (i == 8) ? 1 : 0);
            chk("fill_af",   int'(a_af),   (i >= 7) ? 1 : 0);
        end

        // Simultaneous on full: both accepted, oldest word out
        qa.push_back(8'h01);
        stepa(1, 1, 0, 8'hAA);
        chk("simfull_len",  int'(a_len),  8);
        chk("simfull_ovf",  int'(a_ovf),  0);
        chk("simfull_full", int'(a_full), 1);

        // Overflow
        stepa(1, 0, 0, 8'h09);
        chk("ovf_flag", int'(a_ovf), 1);
        chk("ovf_len",  int'(a_len), 8);

        // Drain: 02..08 then AA; rejected 09 must not appear
        for (int i = 2; i <= 8; i++) qa.push_back(8'(i));
        qa.push_back(8'hAA);
        for (int k = 0; k < 8; k++) begin
            stepa(0, 1, 0, 8'h00);
            chk("drain_len", int'(a_len), 7 - k);
        end
        chk("drain_empty", int'(a_empty), 1);
        chk("drain_ovf_sticky", int'(a_ovf), 1);

        // Simultaneous on empty: enqueue only, underflow set
        stepa(1, 1, 0, 8'h55);
        chk("simempty_udf", int'(a_udf), 1);
        chk("simempty_len", int'(a_len), 1);
        qa.push_back(8'h55);
        stepa(0, 1, 0, 8'h00);
        chk("simempty_deq_len", int'(a_len), 0);
        stepa(0, 1, 0, 8'h00);
        chk("udf_hold_dout", int'(a_dout), 8'h55);
        chk("udf_sticky",    int'(a_udf),  1);

        // Clear with enqueue asserted at count=3 and overflow set
        stepa(1, 0, 0, 8'h61);
        stepa(1, 0, 0, 8'h62);
        stepa(1, 0, 0, 8'h63);
        chk("preclr_len", int'(a_len), 3);
        chk("preclr_ovf", int'(a_ovf), 1);
        stepa(1, 0, 1, 8'h64);
        chk("clr_len",   int'(a_len),   0);
        chk("clr_empty", int'(a_empty), 1);
        chk("clr_ovf",   int'(a_ovf),   0);
        chk("clr_udf",   int'(a_udf),   0);
        chk("clr_dout",  int'(a_dout),  0);
        chk("clr_dv",    int'(a_dv),    0);
        stepa(0, 1, 0, 8'h00);
        chk("clr_nostore_udf", int'(a_udf), 1);
        stepa(1, 0, 0, 8'h71);
        qa.push_back(8'h71);
        stepa(0, 1, 0, 8'h00);
        chk("postclr_len", int'(a_len), 0);

        // Async reset mid-drain at count=5
        for (int i = 0; i < 6; i++) stepa(1, 0, 0, 8'h81 + 8'(i));
        qa.push_back(8'h81);
        stepa(0, 1, 0, 8'h00);
        chk("prerst_len", int'(a_len), 5);
        @(negedge clk);
        #1;
        a_deq = 1'b1;
        rst = 1'b1;
        #1;
        chk("arst_len",   int'(a_len),   0);
        chk("arst_empty", int'(a_empty), 1);
        chk("arst_full",  int'(a_full),  0);
        chk("arst_dv",    int'(a_dv),    0);
        chk("arst_dout",  int'(a_dout),  0);
        chk("arst_ovf",   int'(a_ovf),   0);
        chk("arst_udf",   int'(a_udf),   0);
        @(negedge clk);
        rst = 1'b0;
        a_deq = 1'b0;
        stepa(1, 0, 0, 8'h91);
        chk("resume_len", int'(a_len), 1);
        qa.push_back(8'h91);
        stepa(0, 1, 0, 8'h00);
        chk("resume_dout", int'(a_dout), 8'h91);
        chk("resume_len0", int'(a_len), 0);

        // Wrap on DEPTH=5, AF_THRESH=4
        for (int i = 0; i < 16; i++) begin
            if (wrap_tab[i].d) qb.push_back(wrap_tab[i].dout);
            stepb(wrap_tab[i].e, wrap_tab[i].d, wrap_tab[i].din);
            chk("wrap_len", int'(b_len), wrap_tab[i].len);
            chk("wrap_af",  int'(b_af),  int'(wrap_tab[i].af));
        end
        chk("wrap_empty", int'(b_empty), 1);
        chk("wrap_udf",   int'(b_udf),   0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("a_pending_words", qa.size(), 0);
        chk("b_pending_words", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fila_param.md
Name: fila_param

Overview:
Parametrised circular-buffer FIFO queue, successor to the fixed 8x8 shift-register queue.
- Width and depth are configurable; depth need not be a power of two.
- Single-cycle dequeue with no shifting.
- Simultaneous enqueue/dequeue in the same cycle.
- Status flags: full, empty, almost-full.
- Sticky overflow/underflow error flags and a synchronous flush.
- Sits between the input capture logic and display/consumer logic in the 10 kHz clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries (>=2; any integer)
AF_THRESH, DEPTH-1, almost_full_out asserts when occupancy >= AF_THRESH (1..DEPTH)

Ports:
clk_10KHz  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-high reset
data_in  in  WIDTH  word to enqueue
enqueue_in  in  1  enqueue request, sampled each rising edge
dequeue_in  in  1  dequeue request, sampled each rising edge
clear_in  in  1  synchronous flush
data_out  out  WIDTH  last dequeued word (registered)
data_valid_out  out  1  one-cycle pulse: data_out was updated this cycle
len_out  out  LW=$clog2(DEPTH+1)  current occupancy
full_out  out  1  len_out == DEPTH
empty_out  out  1  len_out == 0
almost_full_out  out  1  len_out >= AF_THRESH
overflow_out  out  1  sticky: an enqueue was rejected
underflow_out  out  1  sticky: a dequeue was rejected

Behaviour:
- Reset (async assert, sampled release): storage, wr_ptr, rd_ptr, count, data_out and error flags all 0. data_valid_out=0, empty_out=1, full_out=0, almost_full_out=0.
- Storage: DEPTH x WIDTH array. wr_ptr and rd_ptr run 0..DEPTH-1 and wrap to 0 by explicit compare against DEPTH-1, not by modulo-2^n.
- Accept rules, evaluated on pre-edge state:
  - deq_ok = dequeue_in && count>0
  - enq_ok = enqueue_in && (count<DEPTH || deq_ok)
- Enqueue: mem[wr_ptr]<=data_in; wr_ptr advances.
- Dequeue: data_out<=mem[rd_ptr]; rd_ptr advances; data_valid_out=1 for exactly that cycle. Otherwise data_out holds its value and data_valid_out=0.
- Latency: a word enqueued at edge N is dequeueable at edge N+1 and visible on data_out after that edge. There is no same-cycle bypass on empty.
- Count update: count <= count + enq_ok - deq_ok. len_out, full_out, empty_out and almost_full_out are derived from the registered count, so they reflect the post-edge occupancy in the same cycle the operation completes. There is no extra lag.
- Simultaneous enq+deq:
  - Full: both accepted; count stays DEPTH; no overflow.
  - Empty: enqueue accepted, dequeue rejected; underflow_out set; count becomes 1.
  - Otherwise: both accepted; count unchanged.
- Rejections: enqueue_in && !enq_ok sets overflow_out; data_in is discarded. dequeue_in && !deq_ok sets underflow_out; data_out is unchanged. Both flags stay set until clear_in or reset.
- clear_in: at the edge, wr_ptr, rd_ptr, count, both error flags and data_out go to 0. data_valid_out=0. It has priority over enqueue/dequeue in the same cycle, which are ignored with no error set. Storage contents need not be cleared.
- Reset mid-operation: immediate return to reset values. Any in-flight request is lost.
- Requests are level-sampled. A request held high for k cycles performs k operations; edge-detection of buttons is upstream.

Decomposition:
- Package fila_pkg: the LW width function (clog2 of DEPTH+1) and a packed struct fila_status_t {full, empty, almost_full, overflow, underflow} for consumers that bundle flags.
- Sub-module fila_ptr: wrapping pointer counter (parameter DEPTH; inputs clk_10KHz, reset, clear, inc; output ptr). It is instantiated twice, for wr_ptr and rd_ptr.
- Storage and count logic live in fila_param.

Test Plan:
- Order: DEPTH=8; enqueue 0x11,0x22,0x33 on consecutive cycles, then three dequeues. data_out shows 0x11,0x22,0x33 with data_valid_out pulsing each cycle; len_out reads 1,2,3 then 2,1,0; empty_out=1 at end.
- Overflow: enqueue 0x01..0x09 (9 cycles). full_out=1 after the 8th; the 9th sets overflow_out=1 and len_out stays 8; draining returns 0x01..0x08.
- Simultaneous: on a full queue, enq 0xAA + deq together → data_out=oldest word, len_out=8, overflow_out=0. On an empty queue, enq 0x55 + deq → underflow_out=1, len_out=1, next dequeue gives 0x55.
- Wrap, DEPTH=5, AF_THRESH=4: 12 interleaved enqueue/dequeue cycles crossing the pointer wrap twice. Output sequence equals input sequence; almost_full_out=1 exactly when len_out>=4.
- clear_in with enq asserted at count=3 and overflow_out set → next cycle len_out=0, empty_out=1, overflow_out=0, data_out=0, no word stored.
- Assert reset asynchronously mid-drain at count=5 → all outputs return to reset values before the next clock edge; operation resumes normally after release.
